// File: rtl/sdram_bridge_pkg.sv
// Shared types and constants for the Wishbone-style bus to SDRAM controller bridge.
package sdram_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DLY   = 3'd3,
    S_ACK   = 3'd4,
    S_DRAIN = 3'd5
  } state_e;

  localparam int WB_ADR_W  = 21;
  localparam int CTL_ADR_W = 22;
  localparam int DAT_W     = 16;
  localparam int RST_CNT_W = 4;
  localparam int WD_W      = 10;
  localparam int DLY_W     = 2;

  localparam logic [DAT_W-1:0] TIMEOUT_FILL = 16'hFFFF;

endpackage

// File: rtl/sdram_rst_delay.sv
// Holds the controller in reset for RST_DELAY cycles after rst_n is released.
module sdram_rst_delay
  import sdram_bridge_pkg::*;
#(
  parameter int RST_DELAY = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic ctl_rst_n
);

  localparam logic [RST_CNT_W-1:0] CNT_LAST = RST_CNT_W'(RST_DELAY);

  logic [RST_CNT_W-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;

  // Counter saturates at CNT_LAST; done is sticky until the next reset.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
    if (cnt_d == CNT_LAST) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign ctl_rst_n = done_q;

endmodule

// File: rtl/sdram_wb_bridge.sv
// Turns level-held bus cycles into single controller requests, with ack delay,
// abort draining and a request watchdog.
module sdram_wb_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int RST_DELAY = 4,
  parameter int ACK_DELAY = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_stb,
  input  logic                 wb_we,
  input  logic [1:0]           wb_sel,
  input  logic [WB_ADR_W-1:0]  wb_adr,
  input  logic [DAT_W-1:0]     wb_dat_i,
  output logic [DAT_W-1:0]     wb_dat_o,
  output logic                 wb_ack,
  output logic                 ctl_rst_n,
  output logic                 ctl_wr_req,
  output logic                 ctl_rd_req,
  input  logic                 ctl_wr_ack,
  input  logic                 ctl_rd_ack,
  output logic [CTL_ADR_W-1:0] ctl_addr,
  output logic [DAT_W-1:0]     ctl_wdata,
  input  logic [DAT_W-1:0]     ctl_rdata,
  input  logic                 ctl_init_done,
  output logic [1:0]           dqm,
  output logic                 ready,
  output logic                 timeout_err
);

  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = (ACK_DELAY > 1) ? DLY_W'(ACK_DELAY - 2) : '0;

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic                 abort_q, abort_d;
  logic                 wr_req_q, wr_req_d;
  logic                 rd_req_q, rd_req_d;
  logic                 tmo_q, tmo_d;
  logic                 ready_q, ready_d;
  logic [1:0]           dqm_q, dqm_d;
  logic [CTL_ADR_W-1:0] addr_q, addr_d;
  logic [DAT_W-1:0]     wdata_q, wdata_d;
  logic [DAT_W-1:0]     rdata_q, rdata_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [DLY_W-1:0]     dly_q, dly_d;
  logic                 ack_hit, abort_now;

  sdram_rst_delay #(.RST_DELAY(RST_DELAY)) u_rst_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctl_rst_n (ctl_rst_n)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    abort_d   = abort_q;
    wr_req_d  = wr_req_q;
    rd_req_d  = rd_req_q;
    tmo_d     = 1'b0;
    ready_d   = ctl_init_done;
    dqm_d     = dqm_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wd_d      = wd_q;
    dly_d     = dly_q;
    // Only the ack matching the latched direction counts.
    ack_hit   = we_q ? ctl_wr_ack : ctl_rd_ack;
    abort_now = abort_q | ~wb_stb;

    unique case (state_q)
      S_IDLE: begin
        if (wb_stb && ready_q && ctl_rst_n) begin
          state_d  = S_REQ;
          we_d     = wb_we;
          abort_d  = 1'b0;
          addr_d   = {1'b0, wb_adr};
          wdata_d  = wb_dat_i;
          dqm_d    = wb_we ? ~wb_sel : 2'b00;
          wr_req_d = wb_we;
          rd_req_d = ~wb_we;
        end
      end
      S_REQ: begin
        abort_d = abort_now;
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        abort_d = abort_now;
        if (ack_hit) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          if (!we_q) rdata_d = ctl_rdata;
          if (ACK_DELAY > 1) begin
            state_d = S_DLY;
            dly_d   = DLY_LOAD;
          end else begin
            state_d = abort_now ? S_DRAIN : S_ACK;
          end
        end else if (wd_q == WD_LAST) begin
          // Watchdog: finish the bus cycle instead of hanging the CPU.
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          tmo_d    = 1'b1;
          if (!we_q) rdata_d = TIMEOUT_FILL;
          state_d  = abort_now ? S_DRAIN : S_ACK;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DLY: begin
        abort_d = abort_now;
        if (dly_q == '0) state_d = abort_now ? S_DRAIN : S_ACK;
        else             dly_d   = dly_q - 1'b1;
      end
      S_ACK: begin
        if (!wb_stb) state_d = S_IDLE;
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      abort_q  <= 1'b0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      tmo_q    <= 1'b0;
      ready_q  <= 1'b0;
      dqm_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wd_q     <= '0;
      dly_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      abort_q  <= abort_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      tmo_q    <= tmo_d;
      ready_q  <= ready_d;
      dqm_q    <= dqm_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wd_q     <= wd_d;
      dly_q    <= dly_d;
    end
  end

  assign wb_ack      = (state_q == S_ACK) & wb_stb;
  assign wb_dat_o    = rdata_q;
  assign ctl_wr_req  = wr_req_q;
  assign ctl_rd_req  = rd_req_q;
  assign ctl_addr    = addr_q;
  assign ctl_wdata   = wdata_q;
  assign dqm         = dqm_q;
  assign ready       = ready_q;
  assign timeout_err = tmo_q;

endmodule

// File: doc/sdram_wb_bridge.md
Name: sdram_wb_bridge

Overview:
- Sits between the topboard SDRAM bus (stb/we/sel/adr/ack, 16-bit data) and the sdram_top request/acknowledge controller.
- Converts level-held bus cycles into single controller requests and drives the SDRAM byte masks.
- Generates the delayed controller reset and the registered bus acknowledge.
- Adds a request watchdog so a stalled controller cannot hang the CPU bus.

Parameters:
- RST_DELAY, 4: cycles ctl_rst_n stays low after rst_n is released (range 1..15).
- ACK_DELAY, 2: cycles from controller ack to wb_ack assertion (range 1..3).
- TIMEOUT, 255: cycles a request may wait for a controller ack before it is aborted (range 16..1023).

Ports:
- clk  in  1  bus and controller clock (100 MHz direct phase)
- rst_n  in  1  synchronous active-low reset
- wb_stb  in  1  bus cycle strobe, held until wb_ack
- wb_we  in  1  1 = write, 0 = read
- wb_sel  in  2  byte selects: [1] high byte, [0] low byte
- wb_adr  in  21  word address, bits 21:1
- wb_dat_i  in  16  write data from the bus
- wb_dat_o  out  16  read data to the bus
- wb_ack  out  1  cycle acknowledge
- ctl_rst_n  out  1  delayed active-low controller reset
- ctl_wr_req  out  1  write request to the controller
- ctl_rd_req  out  1  read request to the controller
- ctl_wr_ack  in  1  controller write acknowledge
- ctl_rd_ack  in  1  controller read acknowledge
- ctl_addr  out  22  controller word address = {1'b0, wb_adr}
- ctl_wdata  out  16  controller write data
- ctl_rdata  in  16  controller read data
- ctl_init_done  in  1  controller initialisation complete
- dqm  out  2  SDRAM masks: [1] UDQM, [0] LDQM, active high
- ready  out  1  registered copy of ctl_init_done
- timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (rst_n = 0 at a clk edge) produces the following register values:
  - ctl_rst_n = 0, reset counter = 0, state = IDLE.
  - All request, acknowledge and error outputs = 0.
  - dqm = 2'b00, wb_dat_o = 0, ctl_addr = 0, ctl_wdata = 0, ready = 0.
- Controller reset release: after rst_n goes high, the counter increments each cycle. When it reaches RST_DELAY, ctl_rst_n goes to 1 and stays there until the next reset.
- State machine: IDLE, REQ, WAIT, DLY, ACK, DRAIN.
- IDLE:
  - Waits for wb_stb = 1 while ready = 1 and ctl_rst_n = 1. wb_stb while not ready is ignored, with no ack.
  - On acceptance, latches ctl_addr, ctl_wdata and the direction.
  - Latches dqm: reads use 2'b00; writes use ~wb_sel.
  - Moves to REQ.
- REQ: asserts ctl_wr_req or ctl_rd_req (exactly one) one cycle after acceptance, then moves to WAIT.
- WAIT:
  - The request stays asserted and the watchdog counts.
  - On the matching ctl_*_ack, drops the request the same cycle it samples the ack. For reads, captures ctl_rdata into wb_dat_o. Moves to DLY.
  - An ack of the wrong direction is ignored.
- DLY: counts ACK_DELAY-1 further cycles, then moves to ACK. With ACK_DELAY = 1, DLY is skipped.
- ACK: wb_ack = 1, held while wb_stb = 1. When wb_stb falls, wb_ack drops in the same cycle (wb_ack is gated combinationally with wb_stb) and the state returns to IDLE.
- Minimum latency from wb_stb accepted to wb_ack is 2 + controller latency + ACK_DELAY cycles.
- Abort: if wb_stb falls while in REQ, WAIT or DLY, the controller transaction still completes. The state then goes to DRAIN, then to IDLE; no wb_ack is ever issued for that cycle.
- New cycle during DRAIN: a new wb_stb is not accepted until the state is back in IDLE.
- Watchdog: if WAIT lasts TIMEOUT cycles:
  - The request is dropped and timeout_err pulses for one cycle.
  - For reads, wb_dat_o = 16'hFFFF.
  - The state moves to ACK, so the bus cycle completes rather than hangs.
- Mid-operation reset: rst_n low in any state returns the block to its reset values on the next edge. No request or ack survives.
- dqm holds its last value in IDLE and changes only at acceptance.
- Simultaneous ctl_wr_ack and ctl_rd_ack: only the ack matching the latched direction is honoured.

Decomposition:
- Shared package sdram_bridge_pkg:
  - state encoding (3-bit enum);
  - address width constants (21, 22) and data width 16;
  - the timeout fill value 16'hFFFF.
- One sub-module, sdram_rst_delay, holds the rst_n to ctl_rst_n counter. The FSM, watchdog and data latches stay in sdram_wb_bridge.

Test Plan:
- Reset release: rst_n low for 5 cycles, then high, with RST_DELAY = 4 → ctl_rst_n rises exactly 4 cycles later; all outputs are 0 during reset.
- Word read: ctl_init_done = 1, then wb_stb = 1, wb_we = 0, wb_adr = 21'h0ABCD; model acks 3 cycles after ctl_rd_req with ctl_rdata = 16'h1234 → ctl_addr = 22'h00ABCD; exactly one request pulse train; dqm = 00; wb_ack asserted 2 cycles after the ack (ACK_DELAY = 2) with wb_dat_o = 16'h1234.
- Byte write: wb_we = 1, wb_sel = 2'b10, wb_dat_i = 16'hA500 → dqm = 2'b01, ctl_wdata = 16'hA500, ctl_wr_req held until ctl_wr_ack, then wb_ack.
- Abort: wb_stb drops 1 cycle after ctl_rd_req → the request remains until ack, no wb_ack at any time, state returns to IDLE; the next cycle is accepted normally.
- Timeout: with TIMEOUT = 16, the model never acks a read → the request drops after 16 WAIT cycles, timeout_err pulses once, wb_ack arrives with wb_dat_o = 16'hFFFF.
- Gating and reset: wb_stb with ctl_init_done = 0 → no request for 50 cycles. Separately, rst_n pulled low during WAIT → the request drops on the next edge and no wb_ack follows.
